alu_issue: RTL and testbench

Issue/writeback stage directly upstream of the 32-bit ALU. Holds an 8-entry x 32-bit register file, accepts 16-bit ALU instructions over a valid/ready handshake, and drives the ALU's `instruction`/`num1`/`num2` inputs for exactly one cycle. It then captures the ALU's registered `result`/`flags` one cycle later and writes the result back to the destination register. It is the first stateful wrapper around the ALU and gives the ALU a defined NOP (opcode 0) whenever no instruction is in flight.

---
 rtl/alu_issue.sv | 185 ++++++++++++++++++
 tb/tb_alu_issue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//
// Purpose:
//   Issue/writeback stage that sits directly in front of the 32-bit ALU.
//   It holds an 8 x DATA_W register file and accepts one 16-bit instruction
//   at a time over a valid/ready handshake. For exactly one cycle (EXEC) it
//   drives the ALU opcode and operands. In the following cycle (WB) it
//   captures the ALU's registered result and flags and writes the result
//   back to the destination register. Whenever no instruction is executing,
//   the ALU is fed a NOP (opcode 0) with zero operands.
//
// Parameters:
//   DATA_W     datapath width (fixed at 32 to match the ALU)
//   REG_RESET  value loaded into every register on reset
//
// Ports:
//   clk             clock, shared with the ALU
//   rst_n           asynchronous active-low reset
//   in_valid        instruction offered
//   in_ready        stage can accept an instruction this cycle
//   in_instr        [15:11] op, [10:8] rd, [7:5] rn, [4] imm, [3:0] rm/imm4
//   alu_instruction ALU opcode (0 = NOP)
//   alu_num1        ALU operand 1 (reg[rn])
//   alu_num2        ALU operand 2 (imm4 zero-extended, or reg[rm])
//   alu_result      registered ALU result
//   alu_flags       registered ALU flags {V,C,Z,N}
//   wb_valid        one-cycle retirement pulse
//   wb_en           a register was written by this retirement
//   wb_rd           destination register of the retirement
//   wb_data         value being retired
//   flags_q         ALU flags captured at the last retirement
//   dbg_addr        debug read address
//   dbg_data        combinational read of reg[dbg_addr]
// ---------------------------------------------------------------------------
module alu_issue #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  REG_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [4:0]        alu_instruction,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [2:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        flags_q,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam logic [4:0] OP_CMP = 5'd18;

    logic [1:0]        state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [3:0]        flags_d;

    // Fields of the latched instruction.
    logic [4:0] op;
    logic [2:0] rd;
    logic [2:0] rn;
    logic       imm;
    logic [3:0] imm4;
    logic [2:0] rm;

    assign op   = instr_q[15:11];
    assign rd   = instr_q[10:8];
    assign rn   = instr_q[7:5];
    assign imm  = instr_q[4];
    assign imm4 = instr_q[3:0];
    assign rm   = instr_q[2:0];

    logic op_valid;   // ALU implements the opcode
    logic op_writes;  // opcode produces a register result (CMP only sets flags)
    logic hs;

    assign op_valid  = (op >= 5'd1) && (op <= OP_CMP);
    assign op_writes = (op >= 5'd1) && (op <  OP_CMP);

    // The stage can accept in IDLE and in WB, so with in_valid held high
    // a new instruction enters EXEC every second cycle.
    assign in_ready = (state_q != S_EXEC);
    assign hs       = in_valid && in_ready;

    // ALU drive: only EXEC presents a real opcode and operands.
    always_comb begin
        alu_instruction = 5'd0;
        alu_num1        = '0;
        alu_num2        = '0;
        if (state_q == S_EXEC) begin
            alu_instruction = op_valid ? op : 5'd0;
            alu_num1        = regs_q[rn];
            alu_num2        = imm ? {{(DATA_W-4){1'b0}}, imm4} : regs_q[rm];
        end
    end

    // Writeback outputs are only meaningful during WB and read as 0 otherwise.
    always_comb begin
        wb_valid = 1'b0;
        wb_en    = 1'b0;
        wb_rd    = 3'd0;
        wb_data  = '0;
        if (state_q == S_WB) begin
            wb_valid = 1'b1;
            wb_en    = op_writes;
            wb_rd    = rd;
            wb_data  = alu_result;
        end
    end

    assign dbg_data = regs_q[dbg_addr];

    // Next-state logic. The WB write lands on the same edge that may move a
    // following instruction into EXEC, so EXEC always reads the fresh value
    // without any bypass path.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        flags_d = flags_q;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    instr_d = in_instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                flags_d = alu_flags;
                if (op_writes) begin
                    regs_d[rd] = alu_result;
                end
                if (hs) begin
                    instr_d = in_instr;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset aborts any in-flight instruction: state returns to IDLE before
    // WB can write, so nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= 16'd0;
            flags_q <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= REG_RESET;
            end
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            flags_q <= flags_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'd0;
    logic [4:0]  alu_instruction;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic [31:0] alu_result = 32'd0;
    logic [3:0]  alu_flags = 4'd0;
    logic        wb_valid;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  flags_q;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    alu_issue #(.DATA_W(32), .REG_RESET(32'h0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .alu_instruction (alu_instruction),
        .alu_num1        (alu_num1),
        .alu_num2        (alu_num2),
        .alu_result      (alu_result),
        .alu_flags       (alu_flags),
        .wb_valid        (wb_valid),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .flags_q         (flags_q),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Minimal registered ALU: ADDS (6), LSLS (11), CMP (18); anything else
    // (including NOP) yields result 0, flags 0. Flags are {V,C,Z,N}.
    function automatic logic [35:0] alu_model(input logic [4:0] ins,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, v;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (ins)
            5'd6: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            5'd11: begin
                t = {1'b0, a} << b[4:0];
                r = t[31:0]; c = (b[4:0] != 5'd0) ? t[32] : 1'b0;
            end
            5'd18: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: begin
                return 36'd0;
            end
        endcase
        return {v, c, (r == 32'd0), r[31], r};
    endfunction

    always @(posedge clk) begin
        logic [35:0] m;
        m = alu_model(alu_instruction, alu_num1, alu_num2);
        alu_flags  <= m[35:32];
        alu_result <= m[31:0];
    end

    function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                        input logic [2:0] rn, input logic im,
                                        input logic [3:0] low);
        return {op, rd, rn, im, low};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
        total++; if (alu_instruction !== 5'd0) begin bad++; $display("FAIL rst_alu_instr got=%0h exp=0", alu_instruction); end
        total++; if (alu_num1 !== 32'd0 || alu_num2 !== 32'd0) begin bad++; $display("FAIL rst_nums got=%0h/%0h exp=0/0", alu_num1, alu_num2); end
        total++; if ({wb_valid, wb_en, wb_rd} !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb got=%0h/%0h/%0h/%0h exp=0", wb_valid, wb_en, wb_rd, wb_data); end
        total++; if (flags_q !== 4'd0) begin bad++; $display("FAIL rst_flags got=%0h exp=0", flags_q); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL rst_reg%0d got=%0h exp=0", i, dbg_data); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_adds_imm();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd6, 3'd1, 3'd0, 1'b1, 4'd5);
        @(negedge clk);                      // EXEC
        in_valid = 1'b0;
        in_instr = 16'hFFFF;                 // must be ignored after handshake
        total++; if (alu_instruction !== 5'd6) begin bad++; $display("FAIL adds_exec_op got=%0d exp=6", alu_instruction); end
        total++; if (alu_num1 !== 32'd0 || alu_num2 !== 32'd5) begin bad++; $display("FAIL adds_exec_nums got=%0h/%0h exp=0/5", alu_num1, alu_num2); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL adds_exec_ready got=%0h exp=0", in_ready); end
        @(negedge clk);                      // WB
        total++; if (alu_instruction !== 5'd0) begin bad++; $display("FAIL adds_wb_nop got=%0d exp=0", alu_instruction); end
        total++; if ({wb_valid, wb_en, wb_rd} !== {1'b1, 1'b1, 3'd1} || wb_data !== 32'd5) begin bad++; $display("FAIL adds_wb got=v%0h e%0h rd%0h d%0h exp=1/1/1/5", wb_valid, wb_en, wb_rd, wb_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL adds_wb_ready got=%0h exp=1", in_ready); end
        @(negedge clk);                      // IDLE
        dbg_addr = 3'd1;
        #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL adds_r1 got=%0h exp=5", dbg_data); end
        total++; if (wb_valid !== 1'b0 || alu_num2 !== 32'd0) begin bad++; $display("FAIL adds_idle got=%0h/%0h exp=0/0", wb_valid, alu_num2); end
        total++; if (flags_q !== 4'b0000) begin bad++; $display("FAIL adds_flags got=%0h exp=0", flags_q); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        t1 = -100; t2 = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd6, 3'd1, 3'd0, 1'b1, 4'd5);
        @(negedge clk);                      // EXEC #1
        in_instr = enc(5'd11, 3'd2, 3'd1, 1'b1, 4'd3);
        total++; if (alu_num2 !== 32'd5) begin bad++; $display("FAIL b2b_exec1_num2 got=%0h exp=5", alu_num2); end
        @(negedge clk);                      // WB #1, second handshake here
        if (wb_valid === 1'b1) t1 = cyc;
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'd5 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_wb1 got=v%0h d%0h r%0h exp=1/5/1", wb_valid, wb_data, in_ready); end
        @(negedge clk);                      // EXEC #2
        in_valid = 1'b0;
        total++; if (alu_instruction !== 5'd11 || alu_num1 !== 32'd5 || alu_num2 !== 32'd3) begin bad++; $display("FAIL b2b_exec2 got=op%0d n1=%0h n2=%0h exp=11/5/3", alu_instruction, alu_num1, alu_num2); end
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_exec2_wbv got=%0h exp=0", wb_valid); end
        @(negedge clk);                      // WB #2
        t2 = cyc;
        total++; if (wb_valid !== 1'b1 || wb_en !== 1'b1 || wb_rd !== 3'd2 || wb_data !== 32'd40) begin bad++; $display("FAIL b2b_wb2 got=v%0h e%0h rd%0h d%0h exp=1/1/2/40", wb_valid, wb_en, wb_rd, wb_data); end
        total++; if (t2 - t1 !== 2) begin bad++; $display("FAIL b2b_spacing got=%0d exp=2", t2 - t1); end
        @(negedge clk);
        dbg_addr = 3'd2;
        #1;
        total++; if (dbg_data !== 32'd40) begin bad++; $display("FAIL b2b_r2 got=%0h exp=40", dbg_data); end
    endtask

    task automatic test_same_reg();
        // ADDS r2,r2,r2: operands see the old 40, destination gets 80
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd6, 3'd2, 3'd2, 1'b0, 4'd2);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (alu_num1 !== 32'd40 || alu_num2 !== 32'd40) begin bad++; $display("FAIL same_nums got=%0h/%0h exp=40/40", alu_num1, alu_num2); end
        @(negedge clk);
        total++; if (wb_data !== 32'd80 || wb_rd !== 3'd2) begin bad++; $display("FAIL same_wb got=%0h rd%0h exp=80/2", wb_data, wb_rd); end
        @(negedge clk);
        dbg_addr = 3'd2;
        #1;
        total++; if (dbg_data !== 32'd80) begin bad++; $display("FAIL same_r2 got=%0h exp=80", dbg_data); end
    endtask

    task automatic test_cmp();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd18, 3'd1, 3'd1, 1'b1, 4'd5);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (alu_instruction !== 5'd18 || alu_num1 !== 32'd5) begin bad++; $display("FAIL cmp_exec got=op%0d n1=%0h exp=18/5", alu_instruction, alu_num1); end
        @(negedge clk);
        total++; if (wb_valid !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL cmp_wb got=v%0h e%0h exp=1/0", wb_valid, wb_en); end
        @(negedge clk);
        dbg_addr = 3'd1;
        #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL cmp_r1 got=%0h exp=5", dbg_data); end
        total++; if (flags_q[1] !== 1'b1) begin bad++; $display("FAIL cmp_zflag got=%0h exp=1", flags_q[1]); end
    endtask

    task automatic test_invalid_op();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd31, 3'd1, 3'd1, 1'b1, 4'd7);
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (alu_instruction !== 5'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL inv_exec got=op%0d r%0h exp=0/0", alu_instruction, in_ready); end
        @(negedge clk);
        total++; if (wb_valid !== 1'b1 || wb_en !== 1'b0) begin bad++; $display("FAIL inv_wb got=v%0h e%0h exp=1/0", wb_valid, wb_en); end
        @(negedge clk);
        dbg_addr = 3'd1;
        #1;
        total++; if (dbg_data !== 32'd5) begin bad++; $display("FAIL inv_r1 got=%0h exp=5", dbg_data); end
        total++; if (flags_q !== 4'd0) begin bad++; $display("FAIL inv_flags got=%0h exp=0", flags_q); end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc(5'd6, 3'd3, 3'd0, 1'b1, 4'd7);
        @(negedge clk);                      // EXEC
        in_valid = 1'b0;
        total++; if (alu_instruction !== 5'd6) begin bad++; $display("FAIL rmid_exec got=%0d exp=6", alu_instruction); end
        rst_n = 1'b0;
        #1;
        total++; if (alu_instruction !== 5'd0 || wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_abort got=op%0d v%0h exp=0/0", alu_instruction, wb_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_wbv1 got=%0h exp=0", wb_valid); end
        @(negedge clk);
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rmid_wbv2 got=%0h exp=0", wb_valid); end
        dbg_addr = 3'd3;
        #1;
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL rmid_r3 got=%0h exp=0", dbg_data); end
        dbg_addr = 3'd2;
        #1;
        total++; if (dbg_data !== 32'd0) begin bad++; $display("FAIL rmid_r2 got=%0h exp=0", dbg_data); end
    endtask

    initial begin
        test_reset();
        test_adds_imm();
        test_back_to_back();
        test_same_reg();
        test_cmp();
        test_invalid_op();
        test_reset();
        test_adds_imm();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
